uart_rx_frame_sequencer: RTL and testbench
==========================================

// Module: uart_rx_frame_sequencer
// PURPOSE
//  Receive-side frame controller for the APB UART. Consumes the already-synchronized
//  serial line RXDI and a 16x oversampling tick BAUDCE, detects and qualifies the start
//  bit and sequences mid-bit sampling of data, parity and stop bits. Delivers one
//  assembled character plus PE/FE/BI status per frame to the RX FIFO/LSR logic.
// PARAMETERS
//  OSR      16  oversampling ticks per bit; power of two, 8..16
//  MID      7   sample point (counter value) inside a bit, 0..OSR-1
// PORTS
//  CLK      in   1  system clock
//  RST      in   1  asynchronous reset, active-high
//  BAUDCE   in   1  oversampling tick, one CLK wide, OSR per bit time
//  CLEAR    in   1  synchronous abort: return to IDLE, clear outputs
//  RXDI     in   1  synchronized serial input (idle high)
//  WLS      in   2  word length: 00=5, 01=6, 10=7, 11=8 bits
//  PEN      in   1  parity enable
//  EPS      in   1  1=even parity, 0=odd parity
//  DOUT     out  8  received character, LSB first, unused MSBs zero
//  DVALID   out  1  one-CLK pulse: DOUT/PE/FE/BI updated
//  PE       out  1  parity error for the frame in DOUT
//  FE       out  1  framing error (stop bit sampled 0)
//  BI       out  1  break: data, parity (if PEN) and stop all 0
//  BUSY     out  1  high in any state other than IDLE
// BEHAVIOUR
//  - Reset (RST=1, async): state IDLE, counter 0, bit index 0, shift reg 0;
//    DOUT=0, DVALID=0, PE=0, FE=0, BI=0, BUSY=0.
//  - All state and counter updates happen only on CLK edges with BAUDCE=1, except
//    DVALID deassert (next CLK) and CLEAR (any CLK edge, highest priority after RST).
//  - 4-bit counter CNT: cleared on entering START; increments on each BAUDCE; wraps
//    OSR-1 -> 0. The decision tick is CNT==SP, where SP = MID, or MID+1 with majority.
//  - FSM:
//    - IDLE:  BAUDCE & RXDI==0 -> START, CNT=0.
//    - START: at SP, sample 1 -> IDLE (false start, no DVALID); sample 0 -> DATA,
//      bit index 0.
//    - DATA:  at SP, shift sample into bit[idx]; after bit WLS+4 -> PARITY if PEN,
//      else STOP.
//    - PARITY: at SP, capture the parity bit -> STOP.
//    - STOP:  at SP, load DOUT, PE, FE, BI; pulse DVALID for one CLK. Stop=1 -> IDLE;
//      stop=0 -> BRKWAIT.
//    - BRKWAIT: stay until BAUDCE & RXDI==1 -> IDLE. This guarantees a single DVALID
//      per break.
//  - Parity check:
//    - EPS=1: XOR of data bits and parity bit must be 0.
//    - EPS=0: that XOR must be 1.
//    - PE=0 when PEN=0.
//  - Only one stop bit is checked; extra stop bits are treated as idle line.
//  - DOUT/PE/FE/BI hold their value until the next DVALID or CLEAR.
//  - WLS/PEN/EPS are sampled continuously; software changes them only while BUSY=0.
//    A change mid-frame gives an undefined character but the FSM must not hang.
//  - CLEAR mid-frame: next cycle state IDLE, CNT=0, all outputs at reset values.
//    A simultaneous frame completion is discarded (no DVALID).
//  - Frame latency from the start-edge tick to DVALID:
//    (1 + nbits + PEN) * OSR + SP BAUDCE ticks, plus 1 CLK.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined:
//    - Each bit is sampled at CNT = MID-1, MID and MID+1.
//    - The decision is the 2-of-3 majority, taken at CNT = MID+1 (SP = MID+1).
//    - A single-tick glitch at the mid-bit is rejected.
//  Undefined:
//    - Single sample at CNT = MID (SP = MID).
//    - No sample-history registers are built.
// TESTING
//  1. 8N1, frame 0xA5 at OSR=16 -> one DVALID, DOUT=0xA5, PE=FE=BI=0, BUSY drops in STOP.
//  2. RXDI low for 3 BAUDCE ticks then high -> START aborts at SP, BUSY=0, no DVALID.
//  3. 7E1 (WLS=10, PEN=1, EPS=1), data 0x55 with parity bit 1 -> DOUT=0x55, PE=1, FE=0.
//  4. Line held low for 20 bit times (8N1) -> exactly one DVALID with DOUT=0x00, FE=1,
//     BI=1; no new frame until RXDI returns high; then 0x3C is received cleanly.
//  5. CLEAR asserted during DATA bit 4 -> next CLK IDLE, BUSY=0, DOUT=0, no DVALID.
//  6. With UART_RX_MAJORITY_EN: 1-tick low glitch at CNT=MID in data bit 0 of 0xFF ->
//     DOUT=0xFF. Without the macro, the same stimulus -> DOUT=0xFE.

Source files
------------

// File: rtl/uart_rx_frame_sequencer.sv
// uart_rx_frame_sequencer
// Receive-side frame controller for the APB UART. It takes the synchronized serial
// line and a 16x oversampling tick. It qualifies the start bit and samples data,
// parity and stop bits at mid-bit. It delivers one character plus PE/FE/BI per frame.
// Optional feature macro: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling around
// the mid-bit point. When the macro is not defined, a single sample is taken at MID.
module uart_rx_frame_sequencer #(
    parameter int OSR = 16,
    parameter int MID = 7
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BAUDCE,
    input  logic       CLEAR,
    input  logic       RXDI,
    input  logic [1:0] WLS,
    input  logic       PEN,
    input  logic       EPS,
    output logic [7:0] DOUT,
    output logic       DVALID,
    output logic       PE,
    output logic       FE,
    output logic       BI,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_BRKWAIT = 3'd5
    } state_e;

`ifdef UART_RX_MAJORITY_EN
    // Majority needs the sample after MID, so the decision moves one tick later.
    localparam logic [3:0] SP = 4'(MID + 1);
`else
    localparam logic [3:0] SP = 4'(MID);
`endif
    localparam logic [3:0] CNT_MAX = 4'(OSR - 1);

    function automatic logic parity8(input logic [7:0] v);
        return ^v;
    endfunction

    function automatic logic [7:0] wls_mask(input logic [1:0] w);
        logic [7:0] m;
        case (w)
            2'b00:   m = 8'h1F;
            2'b01:   m = 8'h3F;
            2'b10:   m = 8'h7F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

`ifdef UART_RX_MAJORITY_EN
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
`endif

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic [7:0] dout_q, dout_d;
    logic       pe_q, pe_d;
    logic       fe_q, fe_d;
    logic       bi_q, bi_d;
    logic       dvalid_q, dvalid_d;
    logic       busy_q, busy_d;

    logic [3:0] cnt_inc_s;
    logic       decide_s;
    logic       sample_s;
    logic       last_bit_s;
    logic [7:0] data_s;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q, hist_d;
    assign sample_s = maj3(hist_q[1], hist_q[0], RXDI);
`else
    assign sample_s = RXDI;
`endif

    assign cnt_inc_s  = (cnt_q == CNT_MAX) ? 4'd0 : cnt_q + 4'd1;
    assign decide_s   = BAUDCE && (cnt_inc_s == SP);
    // The comparison uses >=. A mid-frame WLS change can never strand the bit index.
    assign last_bit_s = (idx_q >= ({1'b0, WLS} + 3'd4));
    assign data_s     = shift_q & wls_mask(WLS);

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: frame sequencing on decision ticks, CLEAR overrides everything.
    always_comb begin
        state_d = state_q;
        if (CLEAR) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (BAUDCE && !RXDI) state_d = S_START;
                    else                 state_d = S_IDLE;
                end
                S_START: begin
                    if (decide_s) state_d = sample_s ? S_IDLE : S_DATA;
                    else          state_d = S_START;
                end
                S_DATA: begin
                    if (decide_s && last_bit_s) state_d = PEN ? S_PARITY : S_STOP;
                    else                        state_d = S_DATA;
                end
                S_PARITY: begin
                    if (decide_s) state_d = S_STOP;
                    else          state_d = S_PARITY;
                end
                S_STOP: begin
                    if (decide_s) state_d = sample_s ? S_IDLE : S_BRKWAIT;
                    else          state_d = S_STOP;
                end
                S_BRKWAIT: begin
                    if (BAUDCE && RXDI) state_d = S_IDLE;
                    else                state_d = S_BRKWAIT;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath next-state: bit counter, bit index, shift register and parity capture.
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
`ifdef UART_RX_MAJORITY_EN
        hist_d  = BAUDCE ? {hist_q[0], RXDI} : hist_q;
`endif
        if (CLEAR) begin
            cnt_d   = 4'd0;
            idx_d   = 3'd0;
            shift_d = 8'h00;
            par_d   = 1'b0;
`ifdef UART_RX_MAJORITY_EN
            hist_d  = 2'b11;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_BRKWAIT: begin
                    cnt_d = 4'd0;
                end
                S_START: begin
                    if (BAUDCE) cnt_d = cnt_inc_s;
                    else        cnt_d = cnt_q;
                    if (decide_s) begin
                        idx_d   = 3'd0;
                        shift_d = 8'h00;
                        par_d   = 1'b0;
                    end else begin
                        idx_d   = idx_q;
                    end
                end
                S_DATA: begin
                    if (BAUDCE) cnt_d = cnt_inc_s;
                    else        cnt_d = cnt_q;
                    if (decide_s) begin
                        shift_d[idx_q] = sample_s;
                        idx_d          = idx_q + 3'd1;
                    end else begin
                        idx_d          = idx_q;
                    end
                end
                S_PARITY: begin
                    if (BAUDCE) cnt_d = cnt_inc_s;
                    else        cnt_d = cnt_q;
                    if (decide_s) par_d = sample_s;
                    else          par_d = par_q;
                end
                S_STOP: begin
                    if (BAUDCE) cnt_d = cnt_inc_s;
                    else        cnt_d = cnt_q;
                end
                default: cnt_d = 4'd0;
            endcase
        end
    end

    // Output next-state: load character/status at the stop decision, one-CLK DVALID.
    always_comb begin
        dout_d   = dout_q;
        pe_d     = pe_q;
        fe_d     = fe_q;
        bi_d     = bi_q;
        dvalid_d = 1'b0;
        busy_d   = (state_d != S_IDLE);
        if (CLEAR) begin
            dout_d = 8'h00;
            pe_d   = 1'b0;
            fe_d   = 1'b0;
            bi_d   = 1'b0;
        end else if ((state_q == S_STOP) && decide_s) begin
            dout_d   = data_s;
            pe_d     = PEN && ((parity8(data_s) ^ par_q) == EPS);
            fe_d     = !sample_s;
            bi_d     = (data_s == 8'h00) && (!PEN || !par_q) && !sample_s;
            dvalid_d = 1'b1;
        end else begin
            dvalid_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q    <= 4'd0;
            idx_q    <= 3'd0;
            shift_q  <= 8'h00;
            par_q    <= 1'b0;
            dout_q   <= 8'h00;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
            bi_q     <= 1'b0;
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            hist_q   <= 2'b11;
`endif
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            dout_q   <= dout_d;
            pe_q     <= pe_d;
            fe_q     <= fe_d;
            bi_q     <= bi_d;
            dvalid_q <= dvalid_d;
            busy_q   <= busy_d;
`ifdef UART_RX_MAJORITY_EN
            hist_q   <= hist_d;
`endif
        end
    end

    assign DOUT   = dout_q;
    assign DVALID = dvalid_q;
    assign PE     = pe_q;
    assign FE     = fe_q;
    assign BI     = bi_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_sequencer.sv
// Testbench for uart_rx_frame_sequencer.
// Serial frames are built tick by tick from their field values, and the expected
// character, status and completion tick are queued as each frame is built.
// A negedge monitor pops one expectation per DVALID and compares it.
module tb_uart_rx_frame_sequencer;

    localparam int OSR = 16;
    localparam int MID = 7;
`ifdef UART_RX_MAJORITY_EN
    localparam int SP = MID + 1;
`else
    localparam int SP = MID;
`endif

    logic       CLK, RST, BAUDCE, CLEAR, RXDI, PEN, EPS;
    logic [1:0] WLS;
    logic [7:0] DOUT;
    logic       DVALID, PE, FE, BI, BUSY;

    typedef struct {
        logic [7:0] dout;
        logic       pe, fe, bi, busy;
        int         t;
    } exp_t;

    exp_t exp_q[$];
    bit   line_q[$];
    int   tick_no = 0;
    int   checks  = 0;
    int   errors  = 0;

    uart_rx_frame_sequencer #(.OSR(OSR), .MID(MID)) dut (
        .CLK(CLK), .RST(RST), .BAUDCE(BAUDCE), .CLEAR(CLEAR), .RXDI(RXDI),
        .WLS(WLS), .PEN(PEN), .EPS(EPS), .DOUT(DOUT), .DVALID(DVALID),
        .PE(PE), .FE(FE), .BI(BI), .BUSY(BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One oversampling tick. Entered and left on a negedge. BAUDCE is high for one posedge.
    task automatic tick(input bit v, input bit clr);
        RXDI   = v;
        BAUDCE = 1'b1;
        CLEAR  = clr;
        tick_no++;
        @(negedge CLK);
        BAUDCE = 1'b0;
        CLEAR  = 1'b0;
        @(negedge CLK);
    endtask

    task automatic play(input int n);
        for (int k = 0; k < n; k++) begin
            if (line_q.size() != 0) tick(line_q.pop_front(), 1'b0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) line_q.push_back(1'b1);
        play(line_q.size());
    endtask

    // Builds one frame on the line queue and, if exp_en, queues its expected result.
    task automatic build_frame(input logic [7:0] data, input logic [1:0] wls, input logic pen,
                               input logic eps, input logic bad_par, input logic stop_v,
                               input int nstop, input bit exp_en);
        int         n;
        int         start;
        logic [7:0] dm;
        logic       p;
        exp_t       e;
        n  = 5 + int'(wls);
        dm = data & 8'((1 << n) - 1);
        p  = (eps ? ^dm : ~^dm) ^ bad_par;
        WLS = wls;
        PEN = pen;
        EPS = eps;
        start = tick_no + line_q.size() + 1;
        repeat (OSR) line_q.push_back(1'b0);
        for (int b = 0; b < n; b++) repeat (OSR) line_q.push_back(dm[b]);
        if (pen) repeat (OSR) line_q.push_back(p);
        repeat (OSR) line_q.push_back(stop_v);
        repeat ((nstop - 1) * OSR) line_q.push_back(1'b1);
        if (exp_en) begin
            e.dout = dm;
            e.pe   = pen & bad_par;
            e.fe   = !stop_v;
            e.bi   = (dm == 8'h00) && (!pen || !p) && !stop_v;
            e.busy = !stop_v;
            e.t    = start + (1 + n + int'(pen)) * OSR + SP;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every DVALID must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST && DVALID) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dvalid: got DOUT=%0h expected no frame", DOUT);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", 32'(DOUT), 32'(e.dout));
                    check("pe", 32'(PE), 32'(e.pe));
                    check("fe", 32'(FE), 32'(e.fe));
                    check("bi", 32'(BI), 32'(e.bi));
                    check("busy_at_dvalid", 32'(BUSY), 32'(e.busy));
                    check("latency_tick", 32'(tick_no), 32'(e.t));
                    @(negedge CLK);
                    check("dvalid_width", 32'(DVALID), 32'd0);
                end
            end
        end
    end

    initial begin
        int dec;
        int s;
        RST = 1'b1; BAUDCE = 1'b0; CLEAR = 1'b0; RXDI = 1'b1;
        WLS = 2'b11; PEN = 1'b0; EPS = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("reset_dout", 32'(DOUT), 32'd0);
        check("reset_dvalid", 32'(DVALID), 32'd0);
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_status", 32'({PE, FE, BI}), 32'd0);
        idle(4);

        // 8N1 0xA5.
        build_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1);
        idle(line_q.size() + 3);

        // False start: 3 low ticks.
        repeat (3) line_q.push_back(1'b0);
        play(1);
        check("false_start_busy_hi", 32'(BUSY), 32'd1);
        idle(20);
        check("false_start_busy_lo", 32'(BUSY), 32'd0);

        // 7E1 0x55 with wrong parity bit (1).
        build_frame(8'h55, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b1);
        idle(line_q.size() + 3);

        // Break: line low for 20 bit times, 8N1.
        WLS = 2'b11; PEN = 1'b0; EPS = 1'b0;
        s = tick_no + 1;
        repeat (20 * OSR) line_q.push_back(1'b0);
        exp_q.push_back('{dout: 8'h00, pe: 1'b0, fe: 1'b1, bi: 1'b1, busy: 1'b1,
                          t: s + 9 * OSR + SP});
        play(line_q.size());
        check("break_busy_hold", 32'(BUSY), 32'd1);
        idle(4);
        check("break_release", 32'(BUSY), 32'd0);
        build_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1);
        idle(line_q.size() + 3);

        // CLEAR in the middle of data bit 4 (no BAUDCE on that edge).
        build_frame(8'h81, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        play((1 + 4) * OSR + 3);
        check("pre_clear_busy", 32'(BUSY), 32'd1);
        CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
        check("clear_busy", 32'(BUSY), 32'd0);
        check("clear_dout", 32'(DOUT), 32'd0);
        check("clear_status", 32'({PE, FE, BI}), 32'd0);
        line_q.delete();
        idle(20);

        // 7O1 frame, then CLEAR coinciding with the stop decision of the next frame.
        build_frame(8'hC3, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1);
        idle(line_q.size() + 3);
        build_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        dec = 9 * OSR + SP;
        play(dec);
        tick(line_q.pop_front(), 1'b1);
        check("clear_at_stop_busy", 32'(BUSY), 32'd0);
        check("clear_at_stop_dout", 32'(DOUT), 32'd0);
        idle(line_q.size() + 3);

        // One-tick low glitch at CNT=MID of data bit 0, frame 0xFF 8N1.
        s = tick_no + 1;
        build_frame(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        line_q[OSR + MID] = 1'b0;
`ifdef UART_RX_MAJORITY_EN
        exp_q.push_back('{dout: 8'hFF, pe: 1'b0, fe: 1'b0, bi: 1'b0, busy: 1'b0,
                          t: s + 9 * OSR + SP});
`else
        exp_q.push_back('{dout: 8'hFE, pe: 1'b0, fe: 1'b0, bi: 1'b0, busy: 1'b0,
                          t: s + 9 * OSR + SP});
`endif
        idle(line_q.size() + 3);

        // Randomized frames: word length, parity, parity errors, framing errors, stop count.
        for (int f = 0; f < 30; f++) begin
            build_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                        ($urandom_range(3, 0) == 0), ($urandom_range(4, 0) != 0),
                        int'($urandom_range(2, 1)), 1'b1);
            idle(line_q.size() + int'($urandom_range(12, 2)));
        end

        idle(40);
        check("pending_frames", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
